char_scroll_display: RTL and testbench

Parametrised 4x4-glyph column-scanning display driver for hex digits. It holds a message buffer of BUF_DEPTH characters, each with a blank flag, and shows a window of NUM_CHARS characters. The window can optionally scroll one column at a time. The block drives the LED column/line matrix directly from the digit-producing logic. Unlike the previous fixed 4-character driver, it keeps scanning while characters are loaded.

---
 rtl/char_scroll_display.sv | 119 +++++++++++
 tb/tb_char_scroll_display.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/char_scroll_display.sv
// Column-scanning LED driver for a window of 4x4 hex glyphs taken from a
// blankable message buffer, with optional one-column-per-step scrolling.
module char_scroll_display #(
    parameter int NUM_CHARS     = 4,
    parameter int BUF_DEPTH     = 8,
    parameter int DWELL         = 1,
    parameter int SCROLL_FRAMES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load,
    input  logic [$clog2(BUF_DEPTH)-1:0]     wr_addr,
    input  logic [3:0]                       data,
    input  logic                             wr_blank,
    input  logic                             scroll_en,
    output logic [$clog2(4*NUM_CHARS)-1:0]   column,
    output logic [3:0]                       line,
    output logic                             frame_start,
    output logic [$clog2(4*BUF_DEPTH)-1:0]   scroll_offset
);
    localparam int NC = 4 * NUM_CHARS;
    localparam int VC = 4 * BUF_DEPTH;
    localparam int CW = $clog2(NC);
    localparam int OW = $clog2(VC);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    logic [DW-1:0]        dwell_cnt;
    logic [CW-1:0]        col_idx;
    logic [FW-1:0]        frame_cnt;
    logic [3:0]           mem [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] blank;

    logic          tick;
    logic          frame_end;
    logic [OW-1:0] vcol;
    logic [AW-1:0] ent;
    logic [3:0]    sel;
    logic [15:0]   glyph;
    logic [3:0]    pix;

    function automatic logic [15:0] glyph_rom(input logic [3:0] d);
        case (d)
            4'h0: glyph_rom = 16'hF99F;
            4'h1: glyph_rom = 16'hF22F;
            4'h2: glyph_rom = 16'hF24F;
            4'h3: glyph_rom = 16'hF71F;
            4'h4: glyph_rom = 16'h99F1;
            4'h5: glyph_rom = 16'hF8F7;
            4'h6: glyph_rom = 16'h8F9F;
            4'h7: glyph_rom = 16'hF111;
            4'h8: glyph_rom = 16'hEBD7;
            4'h9: glyph_rom = 16'hF9F1;
            4'hA: glyph_rom = 16'hF9F9;
            4'hB: glyph_rom = 16'hCADA;
            4'hC: glyph_rom = 16'hF88F;
            4'hD: glyph_rom = 16'hE99E;
            4'hE: glyph_rom = 16'hFE8F;
            default: glyph_rom = 16'hF8E8;
        endcase
    endfunction

    always_comb begin
        tick      = (dwell_cnt == DW'(DWELL - 1));
        frame_end = tick && (col_idx == CW'(NC - 1));
        // VC is a power of two, so the adder's natural overflow is the window wrap
        vcol      = OW'(col_idx) + scroll_offset;
        ent       = vcol[OW-1:2];
        sel       = 4'b1000 >> vcol[1:0];
        glyph     = glyph_rom(mem[ent]);
        pix       = {|(glyph[15:12] & sel), |(glyph[11:8] & sel),
                     |(glyph[7:4] & sel), |(glyph[3:0] & sel)};
    end

    // Buffer writes are independent of scanning; a same-cycle read sees old data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= 4'h0;
            blank <= '1;
        end else if (load) begin
            mem[wr_addr]   <= data;
            blank[wr_addr] <= wr_blank;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt     <= '0;
            col_idx       <= '0;
            frame_cnt     <= '0;
            column        <= '0;
            line          <= 4'h0;
            frame_start   <= 1'b0;
            scroll_offset <= '0;
        end else begin
            dwell_cnt   <= tick ? '0 : dwell_cnt + 1'b1;
            frame_start <= 1'b0;
            if (tick) begin
                column      <= col_idx;
                line        <= blank[ent] ? 4'h0 : pix;
                frame_start <= (col_idx == '0);
                col_idx     <= col_idx + 1'b1;
            end
            // Offset only moves at frame end so every frame uses one offset
            if (!scroll_en) begin
                frame_cnt     <= '0;
                scroll_offset <= '0;
            end else if (frame_end) begin
                if (frame_cnt == FW'(SCROLL_FRAMES - 1)) begin
                    frame_cnt     <= '0;
                    scroll_offset <= scroll_offset + 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_char_scroll_display.sv
// Scoreboard bench: three configurations (base, small scrolling, DWELL=3)
// with expected output words queued ahead and compared every clock.
module tb_char_scroll_display;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit a_done = 0, b_done = 0, c_done = 0;

    // hand-derived glyph columns (line[3] = top row)
    logic [3:0] g0 [4] = '{4'b1111, 4'b1001, 4'b1001, 4'b1111};
    logic [3:0] g1 [4] = '{4'b1001, 4'b1001, 4'b1111, 4'b1001};
    logic [3:0] g8 [4] = '{4'b1110, 4'b1011, 4'b1101, 4'b0111};
    logic [3:0] gf [4] = '{4'b1111, 4'b1010, 4'b1010, 4'b1000};

    logic [31:0] qa[$], qb[$], qc[$];

    // A: NUM_CHARS=4 BUF_DEPTH=8 DWELL=1 SCROLL_FRAMES=16
    logic a_rst, a_load, a_blank, a_scroll, a_fs;
    logic [2:0] a_addr;
    logic [3:0] a_data, a_col, a_line;
    logic [4:0] a_off;
    char_scroll_display #(.NUM_CHARS(4), .BUF_DEPTH(8), .DWELL(1), .SCROLL_FRAMES(16)) dut_a (
        .clk(clk), .reset(a_rst), .load(a_load), .wr_addr(a_addr), .data(a_data),
        .wr_blank(a_blank), .scroll_en(a_scroll), .column(a_col), .line(a_line),
        .frame_start(a_fs), .scroll_offset(a_off));

    // B: NUM_CHARS=2 BUF_DEPTH=4 DWELL=1 SCROLL_FRAMES=1
    logic b_rst, b_load, b_blank, b_scroll, b_fs;
    logic [1:0] b_addr;
    logic [3:0] b_data, b_line, b_off;
    logic [2:0] b_col;
    char_scroll_display #(.NUM_CHARS(2), .BUF_DEPTH(4), .DWELL(1), .SCROLL_FRAMES(1)) dut_b (
        .clk(clk), .reset(b_rst), .load(b_load), .wr_addr(b_addr), .data(b_data),
        .wr_blank(b_blank), .scroll_en(b_scroll), .column(b_col), .line(b_line),
        .frame_start(b_fs), .scroll_offset(b_off));

    // C: NUM_CHARS=4 BUF_DEPTH=8 DWELL=3 SCROLL_FRAMES=16
    logic c_rst, c_load, c_blank, c_scroll, c_fs;
    logic [2:0] c_addr;
    logic [3:0] c_data, c_col, c_line;
    logic [4:0] c_off;
    char_scroll_display #(.NUM_CHARS(4), .BUF_DEPTH(8), .DWELL(3), .SCROLL_FRAMES(16)) dut_c (
        .clk(clk), .reset(c_rst), .load(c_load), .wr_addr(c_addr), .data(c_data),
        .wr_blank(c_blank), .scroll_en(c_scroll), .column(c_col), .line(c_line),
        .frame_start(c_fs), .scroll_offset(c_off));

    function automatic logic [31:0] pk(input int off, input int fs, input int col, input logic [3:0] ln);
        return (32'(off) << 16) | (32'(fs) << 12) | (32'(col) << 4) | 32'(ln);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic drain(input int id);
        int sz;
        for (int n = 0; n < 3000; n++) begin
            sz = (id == 0) ? qa.size() : (id == 1) ? qb.size() : qc.size();
            if (sz == 0) return;
            @(negedge clk);
        end
        chk($sformatf("drain_timeout_%0d", id), 32'(sz), 0);
    endtask

    always @(posedge clk) begin
        #2;
        if (qa.size() > 0) chk($sformatf("a_scan c%0d", a_col), pk(a_off, a_fs, a_col, a_line), qa.pop_front());
        if (qb.size() > 0) chk($sformatf("b_scan c%0d o%0d", b_col, b_off), pk(b_off, b_fs, b_col, b_line), qb.pop_front());
        if (qc.size() > 0) chk($sformatf("c_scan c%0d", c_col), pk(c_off, c_fs, c_col, c_line), qc.pop_front());
    end

    // A: dark idle frames, entry 0 load, same-cycle load/read hazard on entry 1
    initial begin
        a_rst = 1; a_load = 0; a_addr = 0; a_data = 0; a_blank = 1; a_scroll = 0;
        repeat (2) @(negedge clk);
        chk("a_reset", pk(a_off, a_fs, a_col, a_line), 0);
        a_rst = 0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 16; k++) qa.push_back(pk(0, k == 0, k, 4'h0));
        drain(0);
        // load lands on the column-0 tick: that tick still sees the old blank
        a_load = 1; a_addr = 0; a_data = 4'h1; a_blank = 0;
        for (int k = 0; k < 16; k++) qa.push_back(pk(0, k == 0, k, (k >= 1 && k < 4) ? g1[k] : 4'h0));
        @(negedge clk);
        a_load = 0;
        for (int k = 0; k < 16; k++) qa.push_back(pk(0, k == 0, k, (k < 4) ? g1[k] : 4'h0));
        drain(0);
        for (int k = 0; k < 16; k++)
            qa.push_back(pk(0, k == 0, k, (k < 4) ? g1[k] : (k >= 5 && k < 8) ? g8[k-4] : 4'h0));
        repeat (4) @(negedge clk);
        a_load = 1; a_addr = 1; a_data = 4'h8; a_blank = 0;
        @(negedge clk);
        a_load = 0;
        for (int k = 0; k < 16; k++)
            qa.push_back(pk(0, k == 0, k, (k < 4) ? g1[k] : (k < 8) ? g8[k-4] : 4'h0));
        drain(0);
        a_done = 1;
    end

    // B: scrolling through a full wrap, then reset mid-frame
    initial begin
        int oo, v, e, c, off;
        logic [3:0] ln;
        b_rst = 1; b_load = 0; b_addr = 0; b_data = 0; b_blank = 1; b_scroll = 0;
        repeat (2) @(negedge clk);
        chk("b_reset", pk(b_off, b_fs, b_col, b_line), 0);
        b_rst = 0;
        b_load = 1; b_addr = 0; b_data = 4'h8; b_blank = 0;
        @(negedge clk);
        b_addr = 3; b_data = 4'hF;
        @(negedge clk);
        b_load = 0;
        for (int n = 0; n < 50 && b_col != 3'd7; n++) @(negedge clk);
        chk("b_sync", 32'(b_col), 7);
        b_scroll = 1;
        for (int o = 0; o < 18; o++) begin
            oo = o % 16;
            for (int k = 0; k < 8; k++) begin
                v = (k + oo) % 16; e = v / 4; c = v % 4;
                ln = (e == 0) ? g8[c] : (e == 3) ? gf[c] : 4'h0;
                off = (k == 7) ? (oo + 1) % 16 : oo;
                qb.push_back(pk(off, k == 0, k, ln));
            end
        end
        drain(1);
        repeat (3) @(negedge clk);
        b_rst = 1;
        #1;
        chk("b_midreset", pk(b_off, b_fs, b_col, b_line), 0);
        b_scroll = 0;
        @(negedge clk);
        b_rst = 0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 8; k++) qb.push_back(pk(0, k == 0, k, 4'h0));
        drain(1);
        b_done = 1;
    end

    // C: DWELL=3 holds each column three cycles
    initial begin
        c_rst = 1; c_load = 0; c_addr = 0; c_data = 0; c_blank = 1; c_scroll = 0;
        repeat (2) @(negedge clk);
        chk("c_reset", pk(c_off, c_fs, c_col, c_line), 0);
        c_rst = 0;
        c_load = 1; c_addr = 0; c_data = 4'h0; c_blank = 0;
        repeat (2) qc.push_back(pk(0, 0, 0, 4'h0));
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 16; k++)
                for (int d = 0; d < 3; d++)
                    qc.push_back(pk(0, (k == 0 && d == 0), k, (k < 4) ? g0[k] : 4'h0));
        @(negedge clk);
        c_load = 0;
        drain(2);
        c_done = 1;
    end

    initial begin
        int n;
        for (n = 0; n < 20000; n++) begin
            if (a_done && b_done && c_done) break;
            @(negedge clk);
        end
        if (n >= 20000) chk("global_timeout", 32'({a_done, b_done, c_done}), 32'h7);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
